alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational MIPS ALU between NREQ independent requesters, e.g. the main datapath, branch-compare logic and address generation.
- Requesters present operands and an opcode over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle and drives the ALU inputs.
- The ALU result is registered and returned on one shared response channel tagged with the requester id, with backpressure.

Parameters:
- NREQ, 3, number of requesters (2..8).
- IDW, 2, width of the requester id; must satisfy 2**IDW >= NREQ.
- DW, 32, operand and result width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle, one-hot or zero.
- req_a  in  NREQ*DW  flattened A operands; requester i occupies [i*DW +: DW].
- req_b  in  NREQ*DW  flattened B operands.
- req_op  in  NREQ*5  flattened ALU opcodes.
- alu_a  out  DW  to ALU input A.
- alu_b  out  DW  to ALU input B.
- alu_op  out  5  to ALU OP input.
- alu_res  in  DW  from ALU Res output, combinational.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  IDW  index of the requester that owns the response.
- resp_res  out  DW  registered ALU result.
- resp_err  out  1  present only under ALU_OP_CHECK_EN.

Behaviour:
- Reset (rst=1 at a clk edge):
  - resp_valid=0, resp_id=0, resp_res=0, resp_err=0.
  - Round-robin pointer = 0.
  - req_ready=0 while rst is high.
  - alu_op=5'b01111 (NOP), alu_a=0, alu_b=0 while no grant.
- Response register is free when resp_valid=0, or when resp_valid=1 and resp_ready=1 in the same cycle.
- Grant:
  - Happens only when the response register is free and at least one req_valid bit is set.
  - Winner is the first set req_valid bit searching upward from the pointer, wrapping modulo NREQ.
  - At most one grant per cycle.
- Grant cycle, all combinational in the same cycle:
  - req_ready[winner]=1, all other req_ready bits 0.
  - alu_a, alu_b, alu_op = the winner's operands.
- At the next clk edge after a grant:
  - resp_res <= alu_res, resp_id <= winner, resp_valid <= 1.
  - Pointer <= winner+1, wrapping to 0 after NREQ-1.
- Latency and throughput:
  - Request accepted in cycle N; response visible in cycle N+1.
  - One operation per cycle sustained while resp_ready=1.
- Backpressure:
  - resp_valid=1 and resp_ready=0 means no grant, req_ready=0, and resp_* hold stable.
- Free with no request: if resp_valid=1, resp_ready=1 and no req_valid bit is set, resp_valid <= 0 at the edge.
- No grant: alu_op=NOP, alu_a=0, alu_b=0.
- Requesters must hold req_a, req_b and req_op stable while req_valid=1 and req_ready=0. The block does not check this.
- Opcodes are passed through unmodified: 00010 add, 00110 sub, 00111 slt (unsigned), 00000 and, 00001 or, 01111 nop.
- Simultaneous accept and response: when a pending response drains in the same cycle as a new grant, the new result replaces it at the edge with no bubble.
- Mid-operation reset: an in-flight response is dropped, and no request is accepted in the reset cycle.
- NREQ=1: the pointer stays 0 and the block degenerates to a one-stage registered pipe.

Optional Feature:
- Macro: ALU_OP_CHECK_EN.
- Defined:
  - Port resp_err exists.
  - A granted opcode not in {00010, 00110, 00111, 00000, 00001, 01111} is still accepted, but alu_op is driven NOP.
  - The response then carries resp_res=0 and resp_err=1.
  - Legal opcodes give resp_err=0.
- Undefined: there is no resp_err port and opcodes go to the ALU unchanged.

Decomposition:
- Package alu_pkg holds:
  - localparams ALU_ADD=5'b00010, ALU_SUB=5'b00110, ALU_SLT=5'b00111, ALU_AND=5'b00000, ALU_OR=5'b00001, ALU_NOP=5'b01111.
  - Function alu_op_legal(op).
- Sub-module rr_arbiter(NREQ): inputs req vector, pointer and enable; outputs one-hot grant and encoded winner index. Purely combinational.
- The ALU itself stays external so the datapath instance can be reused.

Test Plan:
- Reset, then requester 0 issues add a=5, b=7 -> req_ready[0] in that cycle; next cycle resp_valid=1, resp_id=0, resp_res=12.
- Requesters 0, 1 and 2 all valid continuously with sub 10-3, or 0xF0|0x0F and slt 3<9, resp_ready=1 -> grants in order 0,1,2,0; responses 7, 0xFF, 1 on consecutive cycles.
- Hold resp_ready=0 for 3 cycles after a response with requester 1 valid -> req_ready stays 0 and resp_res/resp_id stay stable; on release, requester 1 is granted in that cycle.
- Assert rst while resp_valid=1 -> next cycle resp_valid=0 and the pointer restarts, so requester 0 wins a three-way contention.
- With ALU_OP_CHECK_EN, requester 2 sends op=5'b10101 -> resp_res=0, resp_err=1, resp_id=2; a following and 0xC&0xA gives resp_res=8, resp_err=0.
- Requester 1 alone, back-to-back ops with resp_ready=1 -> one response per cycle with no bubbles.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode definitions shared by the ALU arbiter and its users, plus an opcode legality helper.
package alu_pkg;

    localparam int unsigned OPW = 5;

    typedef logic [OPW-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 5'b00010;
    localparam alu_op_t ALU_SUB = 5'b00110;
    localparam alu_op_t ALU_SLT = 5'b00111;
    localparam alu_op_t ALU_AND = 5'b00000;
    localparam alu_op_t ALU_OR  = 5'b00001;
    localparam alu_op_t ALU_NOP = 5'b01111;

    function automatic logic alu_op_legal(input alu_op_t op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_AND, ALU_OR, ALU_NOP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                winner      = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NREQ requesters with a registered, tagged response.
// Optional opcode checking (resp_err port, illegal ops forced to NOP) under macro ALU_OP_CHECK_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDW  = 2,
    parameter int unsigned DW   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*DW-1:0]  req_a,
    input  logic [NREQ*DW-1:0]  req_b,
    input  logic [NREQ*OPW-1:0] req_op,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    output logic [OPW-1:0]      alu_op,
    input  logic [DW-1:0]       alu_res,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [DW-1:0]       resp_res
`ifdef ALU_OP_CHECK_EN
    ,
    output logic                resp_err
`endif
);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  winner;
    logic [NREQ-1:0] grant;
    logic            resp_free;
    logic            arb_en;
    logic            granted;
    logic            op_bad;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;
    logic [OPW-1:0]  sel_op;

    // A grant needs a free response slot; nothing is accepted while reset is asserted.
    assign resp_free = !resp_valid || resp_ready;
    assign arb_en    = resp_free && !rst;

    rr_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (arb_en),
        .grant (grant),
        .winner(winner)
    );

    assign granted   = |grant;
    assign req_ready = grant;

    // One-hot operand mux; idle ALU sees zeros and NOP.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = ALU_NOP;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[i*DW +: DW];
                sel_b  = req_b[i*DW +: DW];
                sel_op = req_op[i*OPW +: OPW];
            end
        end
    end

`ifdef ALU_OP_CHECK_EN
    assign op_bad = granted && !alu_op_legal(sel_op);
`else
    assign op_bad = 1'b0;
`endif

    assign alu_a  = sel_a;
    assign alu_b  = sel_b;
    assign alu_op = op_bad ? ALU_NOP : sel_op;

    // Response register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_res   <= '0;
            ptr        <= '0;
        end else if (granted) begin
            resp_valid <= 1'b1;
            resp_id    <= winner;
            resp_res   <= op_bad ? '0 : alu_res;
            ptr        <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef ALU_OP_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else if (granted) begin
            resp_err <= op_bad;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed stimulus pushes expected responses, a monitor pops and compares.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int unsigned NREQ = 3;
    localparam int unsigned IDW  = 2;
    localparam int unsigned DW   = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*DW-1:0]  req_a;
    logic [NREQ*DW-1:0]  req_b;
    logic [NREQ*OPW-1:0] req_op;
    logic [DW-1:0]       alu_a;
    logic [DW-1:0]       alu_b;
    logic [OPW-1:0]      alu_op;
    logic [DW-1:0]       alu_res;
    logic                resp_valid;
    logic                resp_ready;
    logic [IDW-1:0]      resp_id;
    logic [DW-1:0]       resp_res;
`ifdef ALU_OP_CHECK_EN
    logic                resp_err;
`endif

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  res;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_res  (resp_res)
`ifdef ALU_OP_CHECK_EN
        ,
        .resp_err  (resp_err)
`endif
    );

    // External ALU stand-in.
    always_comb begin
        case (alu_op)
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_SLT: alu_res = (alu_a < alu_b) ? 32'd1 : 32'd0;
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            default: alu_res = '0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input logic [DW-1:0] res, input logic err);
        exp_t e;
        e.id  = IDW'(id);
        e.res = res;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input alu_op_t op);
        req_a[i*DW +: DW]   = a;
        req_b[i*DW +: DW]   = b;
        req_op[i*OPW +: OPW] = op;
        req_valid[i]        = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    // Monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got id=%0d res=%0h expected no response", resp_id, resp_res);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id", 64'(resp_id), 64'(e.id));
                chk("resp_res", 64'(resp_res), 64'(e.res));
`ifdef ALU_OP_CHECK_EN
                chk("resp_err", 64'(resp_err), 64'(e.err));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int       g_order [4] = '{0, 1, 2, 0};
    logic [31:0] g_res [4] = '{32'd7, 32'hFF, 32'd1, 32'd7};
    alu_op_t  b_op  [4] = '{ALU_ADD, ALU_OR, ALU_AND, ALU_SUB};
    logic [31:0] b_a [4] = '{32'd1, 32'd8, 32'd6, 32'd100};
    logic [31:0] b_b [4] = '{32'd1, 32'd1, 32'd3, 32'd1};
    logic [31:0] b_res [4] = '{32'd2, 32'd9, 32'd2, 32'd99};

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 32'd1, 32'd1, ALU_ADD);
        tick;
        tick;

        // Reset state with contention present.
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_res", 64'(resp_res), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'(ALU_NOP));
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        tick;
        rst       = 1'b0;
        req_valid = '0;

        // Single add from requester 0.
        set_req(0, 32'd5, 32'd7, ALU_ADD);
        @(negedge clk);
        chk("t1_req_ready", 64'(req_ready), 64'b001);
        chk("t1_alu_a", 64'(alu_a), 64'd5);
        chk("t1_alu_b", 64'(alu_b), 64'd7);
        chk("t1_alu_op", 64'(alu_op), 64'(ALU_ADD));
        push(0, 32'd12, 1'b0);
        tick;
        req_valid = '0;
        @(negedge clk);
        chk("t1_resp_valid", 64'(resp_valid), 64'd1);
        tick;

        // Three-way contention after reset: grants 0,1,2,0.
        do_reset;
        set_req(0, 32'd10, 32'd3, ALU_SUB);
        set_req(1, 32'hF0, 32'h0F, ALU_OR);
        set_req(2, 32'd3, 32'd9, ALU_SLT);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_grant", 64'(req_ready), 64'(3'b001 << g_order[k]));
            push(g_order[k], g_res[k], 1'b0);
            tick;
        end
        req_valid = '0;

        // Backpressure: requester 1 waits while the response is held.
        set_req(1, 32'd1, 32'd2, ALU_ADD);
        @(negedge clk);
        chk("t3_grant", 64'(req_ready), 64'b010);
        push(1, 32'd3, 1'b0);
        tick;
        resp_ready = 1'b0;
        set_req(1, 32'd20, 32'd5, ALU_SUB);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_bp_req_ready", 64'(req_ready), 64'd0);
            chk("t3_bp_valid", 64'(resp_valid), 64'd1);
            chk("t3_bp_id", 64'(resp_id), 64'd1);
            chk("t3_bp_res", 64'(resp_res), 64'd3);
            chk("t3_bp_alu_op", 64'(alu_op), 64'(ALU_NOP));
            tick;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_grant", 64'(req_ready), 64'b010);
        chk("t3_release_alu_a", 64'(alu_a), 64'd20);
        push(1, 32'd15, 1'b0);
        tick;

        // Requester 1 alone, back-to-back with no bubbles.
        for (int k = 0; k < 4; k++) begin
            set_req(1, b_a[k], b_b[k], b_op[k]);
            @(negedge clk);
            chk("t6_grant", 64'(req_ready), 64'b010);
            chk("t6_no_bubble", 64'(resp_valid), 64'd1);
            push(1, b_res[k], 1'b0);
            tick;
        end
        req_valid = '0;

        // Reset with a response in flight; pointer restarts at 0.
        set_req(1, 32'd4, 32'd4, ALU_ADD);
        @(negedge clk);
        chk("t4_inflight_grant", 64'(req_ready), 64'b010);
        tick;
        req_valid  = '0;
        resp_ready = 1'b0;
        rst        = 1'b1;
        set_req(0, 32'hC, 32'hA, ALU_AND);
        set_req(1, 32'd1, 32'd2, ALU_OR);
        set_req(2, 32'd9, 32'd1, ALU_SUB);
        @(negedge clk);
        chk("t4_rst_valid_pending", 64'(resp_valid), 64'd1);
        chk("t4_rst_req_ready", 64'(req_ready), 64'd0);
        tick;
        rst        = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("t4_dropped", 64'(resp_valid), 64'd0);
        chk("t4_ptr_restart", 64'(req_ready), 64'b001);
        push(0, 32'd8, 1'b0);
        tick;
        req_valid = '0;

        // Unknown opcode, then a legal and.
        set_req(2, 32'd3, 32'd4, 5'b10101);
        @(negedge clk);
        chk("t5_grant", 64'(req_ready), 64'b100);
`ifdef ALU_OP_CHECK_EN
        chk("t5_alu_op_nop", 64'(alu_op), 64'(ALU_NOP));
        push(2, 32'd0, 1'b1);
`else
        chk("t5_alu_op_pass", 64'(alu_op), 64'b10101);
        push(2, 32'd0, 1'b0);
`endif
        tick;
        set_req(2, 32'hC, 32'hA, ALU_AND);
        @(negedge clk);
        chk("t5_and_grant", 64'(req_ready), 64'b100);
        push(2, 32'd8, 1'b0);
        tick;
        req_valid = '0;
        tick;
        tick;
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
